// File: rtl/axi_mst_read_mo_if.sv
// AXI4 read address/data channels plus the AXI-Stream
// output of the multi-outstanding read master.
interface axi_mst_read_mo_if #(
  parameter int ID_WIDTH   = 6,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
);
  logic [ID_WIDTH-1:0]     m_axi_arid;
  logic [31:0]             m_axi_araddr;
  logic [LEN_WIDTH-1:0]    m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic                    m_axi_arlock;
  logic [3:0]              m_axi_arcache;
  logic [2:0]              m_axi_arprot;
  logic [3:0]              m_axi_arqos;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [ID_WIDTH-1:0]     m_axi_rid;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic [DATA_WIDTH-1:0]   m_axis_tdata;
  logic [DATA_WIDTH/8-1:0] m_axis_tstrb;
  logic                    m_axis_tlast;

  modport master (
    output m_axi_arid, m_axi_araddr, m_axi_arlen,
    output m_axi_arsize, m_axi_arburst, m_axi_arlock,
    output m_axi_arcache, m_axi_arprot, m_axi_arqos,
    output m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp,
    input  m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tvalid, m_axis_tdata,
    output m_axis_tstrb, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axi_arid, m_axi_araddr, m_axi_arlen,
    input  m_axi_arsize, m_axi_arburst, m_axi_arlock,
    input  m_axi_arcache, m_axi_arprot, m_axi_arqos,
    input  m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp,
    output m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tvalid, m_axis_tdata,
    input  m_axis_tstrb, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/axi_mst_read_mo.sv
// Multi-outstanding AXI4 INCR read master: FIFO space is
// reserved per burst before AR, read data leaves on AXIS.
module axi_mst_read_mo #(
  parameter int ID_WIDTH   = 6,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8,
  parameter int MAX_OT     = 4,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  axi_mst_read_mo_if.master    bus,
  input  logic                 START_REG,
  input  logic [31:0]          ADDR_REG,
  input  logic [31:0]          NBURST_REG,
  input  logic [LEN_WIDTH-1:0] BLEN_REG,
  output logic                 RIDLE_REG,
  output logic                 RERR_REG,
  output logic [31:0]          BEATS_REG
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int OW    = $clog2(MAX_OT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t               r_state;
  logic [31:0]          r_addr;
  logic [31:0]          r_nburst;
  logic [31:0]          r_issued;
  logic [31:0]          r_total;
  logic [31:0]          r_beats;
  logic [LEN_WIDTH-1:0] r_blen;
  logic [OW-1:0]        r_ot;
  logic [CW-1:0]        r_rsv;
  logic [CW-1:0]        r_cnt;
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic                 r_rerr;
  logic                 r_arvalid;
  logic [31:0]          r_araddr;
  logic [LEN_WIDTH-1:0] r_arlen;
  logic [DATA_WIDTH:0]  r_mem [FIFO_DEPTH];

  logic                 w_ar_hs;
  logic                 w_rready;
  logic                 w_tvalid;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_rlast;
  logic                 w_push_last;
  logic [LEN_WIDTH:0]   w_burst;
  logic [OW-1:0]        w_ot_nxt;
  logic [CW-1:0]        w_rsv_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [31:0]          w_issued_nxt;
  logic [31:0]          w_addr_nxt;
  logic [31:0]          w_free_nxt;
  logic                 w_can_issue;
  logic [DATA_WIDTH:0]  w_head;
  logic [ID_WIDTH-1:0]  w_unused_rid;

  assign w_ar_hs   = r_arvalid & bus.m_axi_arready;
  assign w_rready  = (r_cnt != CW'(FIFO_DEPTH));
  assign w_tvalid  = (r_cnt != '0);
  assign w_push    = bus.m_axi_rvalid & w_rready;
  assign w_pop     = w_tvalid & bus.m_axis_tready;
  assign w_rlast   = w_push & bus.m_axi_rlast;
  assign w_burst   = {1'b0, r_blen} + 1'b1;
  assign w_push_last = (r_beats + 32'd1 == r_total);

  assign w_ot_nxt  = r_ot + OW'(w_ar_hs)
                   - OW'(w_rlast);
  assign w_rsv_nxt = r_rsv
                   + (w_ar_hs ? CW'(w_burst) : '0)
                   - CW'(w_push);
  assign w_cnt_nxt = r_cnt + CW'(w_push)
                   - CW'(w_pop);
  assign w_issued_nxt = r_issued + 32'(w_ar_hs);
  assign w_addr_nxt = w_ar_hs
    ? r_addr + (32'(w_burst) << SZ) : r_addr;
  assign w_free_nxt = 32'(FIFO_DEPTH)
                    - 32'(w_cnt_nxt)
                    - 32'(w_rsv_nxt);

  // Launch a burst only when an OT slot and its whole
  // FIFO footprint are free after this cycle's updates.
  assign w_can_issue = (r_state == S_RUN)
    && (w_issued_nxt < r_nburst)
    && (32'(w_ot_nxt) < 32'(MAX_OT))
    && (w_free_nxt >= 32'(w_burst));

  assign w_head       = r_mem[r_rptr];
  assign w_unused_rid = bus.m_axi_rid;

  assign bus.m_axi_arid    = '0;
  assign bus.m_axi_araddr  = r_araddr;
  assign bus.m_axi_arlen   = r_arlen;
  assign bus.m_axi_arsize  = 3'(SZ);
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arlock  = 1'b0;
  assign bus.m_axi_arcache = 4'd0;
  assign bus.m_axi_arprot  = 3'd0;
  assign bus.m_axi_arqos   = 4'd0;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_rready  = w_rready;
  assign bus.m_axis_tvalid = w_tvalid;
  assign bus.m_axis_tdata  = w_head[DATA_WIDTH-1:0];
  assign bus.m_axis_tstrb  = '1;
  assign bus.m_axis_tlast  = w_tvalid & w_head[DATA_WIDTH];

  assign RIDLE_REG = (r_state == S_IDLE);
  assign RERR_REG  = r_rerr;
  assign BEATS_REG = r_beats;

  // FIFO storage: data word plus end-of-job flag.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_push_last, bus.m_axi_rdata};
    end
  end

  // Job FSM, AR issue, OT/reservation and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_nburst  <= '0;
      r_issued  <= '0;
      r_total   <= '0;
      r_beats   <= '0;
      r_blen    <= '0;
      r_ot      <= '0;
      r_rsv     <= '0;
      r_cnt     <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_rerr    <= 1'b0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
    end else begin
      r_ot     <= w_ot_nxt;
      r_rsv    <= w_rsv_nxt;
      r_cnt    <= w_cnt_nxt;
      r_issued <= w_issued_nxt;
      r_addr   <= w_addr_nxt;
      if (w_push) begin
        r_wptr  <= r_wptr + AW'(1);
        r_beats <= r_beats + 32'd1;
        if (bus.m_axi_rresp != 2'b00) begin
          r_rerr <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (!r_arvalid || bus.m_axi_arready) begin
        r_arvalid <= w_can_issue;
        r_araddr  <= w_addr_nxt;
        r_arlen   <= r_blen;
      end
      unique case (r_state)
        S_IDLE: begin
          if (START_REG) r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_addr   <= ADDR_REG & ~32'(BYTES - 1);
          r_nburst <= NBURST_REG;
          r_blen   <= BLEN_REG;
          r_total  <= NBURST_REG
                    * (32'(BLEN_REG) + 32'd1);
          r_beats  <= '0;
          r_rerr   <= 1'b0;
          r_issued <= '0;
          r_state  <= (NBURST_REG == '0)
                    ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (w_issued_nxt == r_nburst)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_ot == '0 && r_cnt == '0)
            r_state <= S_DONE;
        end
        S_DONE: begin
          if (!START_REG) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_mst_read_mo.sv
// Randomised bench for axi_mst_read_mo: AXI slave model,
// AXIS sink and an address-based expected stream.
module tb_axi_mst_read_mo;
  localparam int IW = 6;
  localparam int DW = 64;
  localparam int LW = 8;
  localparam int OT = 4;
  localparam int FD = 64;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          START = 1'b0;
  logic [31:0]   ADDR = '0;
  logic [31:0]   NBURST = '0;
  logic [LW-1:0] BLEN = '0;
  logic          RIDLE;
  logic          RERR;
  logic [31:0]   BEATS;

  axi_mst_read_mo_if #(
    .ID_WIDTH(IW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) bus ();

  axi_mst_read_mo #(
    .ID_WIDTH(IW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
    .MAX_OT(OT), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .START_REG(START), .ADDR_REG(ADDR),
    .NBURST_REG(NBURST), .BLEN_REG(BLEN),
    .RIDLE_REG(RIDLE), .RERR_REG(RERR),
    .BEATS_REG(BEATS)
  );

  int ncmp = 0;
  int nerr = 0;

  // slave / sink knobs (written by tests only)
  int arready_pct = 100;
  int r_pct = 100;
  bit r_enable = 1'b1;
  int r_limit = -1;
  int tready_mode = 1;
  bit err_on = 1'b0;
  int err_burst = 0;
  int err_beat = 0;

  // per-job observations (written by the slave model only)
  typedef struct {
    logic [31:0] a;
    int          len;
  } ar_t;
  ar_t         arq[$];
  logic [31:0] ar_log[$];
  logic [63:0] obs_d[$];
  bit          obs_l[$];
  int ar_cnt = 0;
  int beats_sent = 0;
  int rburst = 0;
  int rk = 0;
  int cyc = 0;
  int rlast1_cyc = -1;
  int ar5_cyc = -1;
  bit r_stall = 1'b0;
  bit arv_seen = 1'b0;

  function automatic logic [63:0] word_of(
    input logic [31:0] a
  );
    return {~a, a};
  endfunction

  // AXI slave + AXIS sink; handshakes are predicted from
  // values that stay stable until the next rising edge.
  initial begin
    bit p_ar, p_r, p_t, c_rlast, c_tlast, start_q;
    logic [31:0] c_araddr, a;
    logic [63:0] c_tdata;
    int c_arlen;
    p_ar = 0; p_r = 0; p_t = 0; start_q = 0;
    c_rlast = 0; c_tlast = 0; c_arlen = 0;
    c_araddr = '0; c_tdata = '0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata = '0;
    bus.m_axi_rresp = 2'b00;
    bus.m_axi_rlast = 1'b0;
    bus.m_axi_rid = '0;
    bus.m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rstn) begin
        arq.delete();
        rk = 0;
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast = 1'b0;
        p_ar = 0; p_r = 0; p_t = 0;
        start_q = 0;
      end else begin
        if (p_ar) begin
          arq.push_back('{c_araddr, c_arlen});
          ar_log.push_back(c_araddr);
          ar_cnt++;
          if (ar_cnt == 5) ar5_cyc = cyc;
        end
        if (p_r) begin
          beats_sent++;
          bus.m_axi_rvalid = 1'b0;
          if (c_rlast) begin
            rk = 0;
            rburst++;
            if (arq.size() > 0) void'(arq.pop_front());
            if (rlast1_cyc < 0) rlast1_cyc = cyc;
          end else begin
            rk++;
          end
        end
        if (p_t) begin
          obs_d.push_back(c_tdata);
          obs_l.push_back(c_tlast);
        end
        if (START && !start_q) begin
          ar_log.delete(); obs_d.delete(); obs_l.delete();
          ar_cnt = 0; beats_sent = 0; rburst = 0;
          rlast1_cyc = -1; ar5_cyc = -1;
          r_stall = 0; arv_seen = 0;
        end
        start_q = START;
        bus.m_axi_arready =
          ($urandom_range(99) < arready_pct);
        if (!bus.m_axi_rvalid && r_enable
            && (r_limit < 0 || beats_sent < r_limit)
            && arq.size() > 0
            && $urandom_range(99) < r_pct) begin
          a = arq[0].a + 32'(rk * 8);
          bus.m_axi_rdata = word_of(a);
          bus.m_axi_rlast = (rk == arq[0].len);
          bus.m_axi_rresp = (err_on && rburst == err_burst
                             && rk == err_beat)
                            ? 2'b10 : 2'b00;
          bus.m_axi_rid = IW'($urandom_range(63));
          bus.m_axi_rvalid = 1'b1;
        end
        case (tready_mode)
          1: bus.m_axis_tready = 1'b1;
          2: bus.m_axis_tready = 1'b0;
          default: bus.m_axis_tready = $urandom_range(1) == 1;
        endcase
        p_ar = bus.m_axi_arvalid && bus.m_axi_arready;
        c_araddr = bus.m_axi_araddr;
        c_arlen = int'(bus.m_axi_arlen);
        p_r = bus.m_axi_rvalid && bus.m_axi_rready;
        c_rlast = bus.m_axi_rlast;
        p_t = bus.m_axis_tvalid && bus.m_axis_tready;
        c_tdata = bus.m_axis_tdata;
        c_tlast = bus.m_axis_tlast;
        if (bus.m_axi_rvalid && !bus.m_axi_rready)
          r_stall = 1'b1;
        if (bus.m_axi_arvalid) arv_seen = 1'b1;
      end
    end
  end

  // expected stream: beat i of the job reads base + i*8
  function automatic int stream_bad(
    input logic [31:0] a0, input int total
  );
    int bad;
    logic [31:0] base;
    bad = 0;
    base = a0 & ~32'h7;
    if (obs_d.size() != total) return total + 1;
    for (int i = 0; i < total; i++) begin
      if (obs_d[i] !== word_of(base + 32'(i * 8)))
        bad++;
      if (obs_l[i] !== (i == total - 1))
        bad++;
    end
    return bad;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_job(
    input logic [31:0] a, input int nb, input int bl
  );
    ADDR = a;
    NBURST = 32'(nb);
    BLEN = LW'(bl);
    START = 1'b1;
    tick(3);
  endtask

  task automatic wait_job(
    input int nb, input int bl, output bit to
  );
    to = 1'b1;
    for (int k = 0; k < 20000; k++) begin
      if (ar_cnt == nb
          && obs_d.size() == nb * (bl + 1)) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    tick(3);
  endtask

  task automatic end_job();
    START = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    ncmp += 7;
    if (bus.m_axi_arvalid !== 1'b0) begin
      nerr++; $display("FAIL rst_arvalid got %b want 0",
                       bus.m_axi_arvalid);
    end
    if (bus.m_axis_tvalid !== 1'b0) begin
      nerr++; $display("FAIL rst_tvalid got %b want 0",
                       bus.m_axis_tvalid);
    end
    if (bus.m_axis_tlast !== 1'b0) begin
      nerr++; $display("FAIL rst_tlast got %b want 0",
                       bus.m_axis_tlast);
    end
    if (bus.m_axi_rready !== 1'b1) begin
      nerr++; $display("FAIL rst_rready got %b want 1",
                       bus.m_axi_rready);
    end
    if (RIDLE !== 1'b1) begin
      nerr++; $display("FAIL rst_ridle got %b want 1", RIDLE);
    end
    if (RERR !== 1'b0) begin
      nerr++; $display("FAIL rst_rerr got %b want 0", RERR);
    end
    if (BEATS !== 32'd0) begin
      nerr++; $display("FAIL rst_beats got %0d want 0", BEATS);
    end
  endtask

  task automatic test_basic();
    bit to;
    int bad;
    arready_pct = 100; r_pct = 100; tready_mode = 1;
    start_job(32'h1000, 4, 7);
    wait_job(4, 7, to);
    ncmp++;
    if (to) begin
      nerr++; $display("FAIL basic_timeout got 1 want 0");
    end
    for (int b = 0; b < 4; b++) begin
      ncmp++;
      if (b >= ar_log.size()) begin
        nerr++;
        $display("FAIL basic_araddr%0d got none want %h",
                 b, 32'h1000 + 32'(b * 64));
      end else if (ar_log[b] !== 32'h1000 + 32'(b * 64)) begin
        nerr++;
        $display("FAIL basic_araddr%0d got %h want %h",
                 b, ar_log[b], 32'h1000 + 32'(b * 64));
      end
    end
    bad = stream_bad(32'h1000, 32);
    ncmp++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL basic_stream got %0d words %0d bad want 32 words 0 bad",
               obs_d.size(), bad);
    end
    ncmp++;
    if (BEATS !== 32'd32) begin
      nerr++; $display("FAIL basic_beats got %0d want 32", BEATS);
    end
    ncmp++;
    if (RIDLE !== 1'b0) begin
      nerr++; $display("FAIL basic_done_ridle got %b want 0", RIDLE);
    end
    end_job();
    ncmp++;
    if (RIDLE !== 1'b1) begin
      nerr++; $display("FAIL basic_idle got %b want 1", RIDLE);
    end
  endtask

  task automatic test_max_ot();
    bit to;
    int bad;
    logic [31:0] a;
    a = $urandom & 32'h0FFF_FF00;
    arready_pct = 100; tready_mode = 0; r_enable = 1'b0;
    start_job(a, 6, 3);
    tick(50);
    ncmp++;
    if (ar_cnt != OT || beats_sent != 0) begin
      nerr++;
      $display("FAIL ot_hold got ar=%0d r=%0d want ar=%0d r=0",
               ar_cnt, beats_sent, OT);
    end
    r_enable = 1'b1;
    wait_job(6, 3, to);
    ncmp++;
    if (to || !(ar5_cyc > rlast1_cyc && rlast1_cyc > 0)) begin
      nerr++;
      $display("FAIL ot_fifth got ar5=%0d rlast1=%0d to=%0d want ar5>rlast1",
               ar5_cyc, rlast1_cyc, to);
    end
    bad = stream_bad(a, 24);
    ncmp++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL ot_stream got %0d words %0d bad want 24 words 0 bad",
               obs_d.size(), bad);
    end
    end_job();
  endtask

  task automatic test_backpressure();
    bit to;
    int bad;
    logic [31:0] a;
    a = $urandom & 32'h0FFF_F000;
    arready_pct = 100; r_pct = 100; tready_mode = 2;
    start_job(a, 6, 15);
    tick(100);
    ncmp++;
    if (ar_cnt != 4 || beats_sent != 64 || BEATS !== 32'd64) begin
      nerr++;
      $display("FAIL bp_hold got ar=%0d r=%0d beats=%0d want 4/64/64",
               ar_cnt, beats_sent, BEATS);
    end
    ncmp++;
    if (r_stall) begin
      nerr++; $display("FAIL bp_rready_stall got 1 want 0");
    end
    tready_mode = 0;
    wait_job(6, 15, to);
    bad = stream_bad(a, 96);
    ncmp++;
    if (to || bad != 0 || r_stall) begin
      nerr++;
      $display("FAIL bp_stream got to=%0d bad=%0d stall=%0d want 0/0/0",
               to, bad, r_stall);
    end
    end_job();
  endtask

  task automatic test_nburst0();
    ADDR = 32'h2000; NBURST = 0; BLEN = 8'd3;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    ncmp++;
    if (RIDLE !== 1'b0) begin
      nerr++; $display("FAIL nb0_done_ridle got %b want 0", RIDLE);
    end
    tick();
    ncmp++;
    if (RIDLE !== 1'b1) begin
      nerr++; $display("FAIL nb0_idle got %b want 1", RIDLE);
    end
    tick(3);
    ncmp++;
    if (arv_seen || BEATS !== 32'd0) begin
      nerr++;
      $display("FAIL nb0_quiet got arv=%0d beats=%0d want 0/0",
               arv_seen, BEATS);
    end
  endtask

  task automatic test_rerr();
    bit to;
    int bad, bl;
    logic [31:0] a;
    a = $urandom;
    bl = $urandom_range(7, 1);
    err_on = 1'b1; err_burst = 1;
    err_beat = $urandom_range(bl);
    arready_pct = 70; r_pct = 70; tready_mode = 0;
    start_job(a, 4, bl);
    wait_job(4, bl, to);
    bad = stream_bad(a, 4 * (bl + 1));
    ncmp++;
    if (RERR !== 1'b1) begin
      nerr++; $display("FAIL rerr_set got %b want 1", RERR);
    end
    ncmp++;
    if (to || bad != 0) begin
      nerr++;
      $display("FAIL rerr_stream got to=%0d bad=%0d want 0/0", to, bad);
    end
    end_job();
    err_on = 1'b0;
    start_job($urandom, 2, bl);
    ncmp++;
    if (RERR !== 1'b0) begin
      nerr++; $display("FAIL rerr_clear got %b want 0", RERR);
    end
    wait_job(2, bl, to);
    end_job();
  endtask

  task automatic test_random();
    bit to;
    int bad, nb, bl, abad;
    logic [31:0] a, base;
    for (int j = 0; j < 5; j++) begin
      a = (j == 0) ? 32'hFFFF_FFC5 : $urandom;
      base = a & ~32'h7;
      nb = $urandom_range(6, 1);
      bl = $urandom_range(15);
      arready_pct = $urandom_range(100, 30);
      r_pct = $urandom_range(100, 30);
      tready_mode = 0;
      start_job(a, nb, bl);
      wait_job(nb, bl, to);
      bad = stream_bad(a, nb * (bl + 1));
      abad = 0;
      for (int b = 0; b < ar_log.size(); b++)
        if (ar_log[b] !== base + 32'(b * (bl + 1) * 8))
          abad++;
      ncmp++;
      if (to || bad != 0 || abad != 0) begin
        nerr++;
        $display("FAIL rnd%0d_stream got to=%0d bad=%0d abad=%0d want 0/0/0",
                 j, to, bad, abad);
      end
      ncmp++;
      if (BEATS !== 32'(nb * (bl + 1)) || RERR !== 1'b0) begin
        nerr++;
        $display("FAIL rnd%0d_regs got beats=%0d rerr=%b want %0d/0",
                 j, BEATS, RERR, nb * (bl + 1));
      end
      end_job();
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int bad, k;
    logic [31:0] a;
    arready_pct = 100; r_pct = 100;
    tready_mode = 2; r_limit = 5;
    start_job(32'h4000, 3, 15);
    k = 0;
    while (!(ar_cnt == 3 && beats_sent == 5) && k < 300) begin
      tick();
      k++;
    end
    tick(2);
    ncmp++;
    if (k >= 300 || BEATS !== 32'd5) begin
      nerr++;
      $display("FAIL mid_pre got beats=%0d ar=%0d want 5/3",
               BEATS, ar_cnt);
    end
    rstn = 1'b0;
    START = 1'b0;
    tick();
    ncmp++;
    if (bus.m_axi_arvalid !== 1'b0 || bus.m_axis_tvalid !== 1'b0
        || RIDLE !== 1'b1 || BEATS !== 32'd0) begin
      nerr++;
      $display("FAIL mid_rst got arv=%b tv=%b ridle=%b beats=%0d want 0/0/1/0",
               bus.m_axi_arvalid, bus.m_axis_tvalid, RIDLE, BEATS);
    end
    tick(2);
    rstn = 1'b1;
    r_limit = -1;
    tready_mode = 0;
    tick(2);
    a = $urandom;
    start_job(a, 3, 9);
    wait_job(3, 9, to);
    bad = stream_bad(a, 30);
    ncmp++;
    if (to || bad != 0 || BEATS !== 32'd30) begin
      nerr++;
      $display("FAIL mid_after got to=%0d bad=%0d beats=%0d want 0/0/30",
               to, bad, BEATS);
    end
    end_job();
  endtask

  initial begin
    tick(5);
    rstn = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_max_ot();
    test_backpressure();
    test_nburst0();
    test_rerr();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end
endmodule
